encoder_arb_ctrl: RTL and testbench
===================================

ENCODER_ARB_CTRL -- requirements
Module: encoder_arb_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one encoder datapath.
REQ-002 SHALL have parameter DW, default 16: encoder input word width.
REQ-003 SHALL have parameter OW, default 8: encoder result width.
REQ-004 SHALL have parameter TMO, default 255: WAIT-state timeout in cycles, range 1..255.
REQ-005 SHALL have port wb_clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, NREQ: per-requester request valid.
REQ-008 SHALL have port req_data, input, NREQ*DW: request word; requester i in bits [i*DW +: DW].
REQ-009 SHALL have port req_ready, output, NREQ: one-hot accept strobe.
REQ-010 SHALL have port enc_valid, output, 1: word offered to the encoder.
REQ-011 SHALL have port enc_data, output, DW: word to the encoder.
REQ-012 SHALL have port enc_ready, input, 1: encoder accepts the word.
REQ-013 SHALL have port enc_done, input, 1: encoder result valid, single-cycle pulse.
REQ-014 SHALL have port enc_result, input, OW: encoder result.
REQ-015 SHALL have port rsp_valid, output, NREQ: one-hot, one-cycle response strobe to the granted requester.
REQ-016 SHALL have port rsp_data, output, OW: result returned; zero on timeout.
REQ-017 SHALL have port rsp_err, output, 1: qualifies rsp_valid; 1 = timeout.
REQ-018 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-019 SHALL have port grant_id, output, clog2(NREQ): index of the current or last granted requester.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-021 IDLE: if any req_valid, SHALL assert req_ready only for the round-robin winner, combinationally in that cycle, latch its req_data and index, and go to ISSUE; otherwise stay in IDLE.
REQ-022 Round-robin SHALL search from (last_grant+1) mod NREQ upward with wrap; last_grant updates at acceptance.
REQ-023 ISSUE: enc_valid=1 and enc_data=latched word, held stable until enc_ready; on enc_valid&&enc_ready SHALL go to WAIT with the timeout counter cleared.
REQ-024 WAIT: counter increments each cycle; on enc_done SHALL latch enc_result, clear err, and go to RESP.
REQ-025 WAIT: counter reaching TMO-1 without enc_done SHALL set err, force the result to 0, and go to RESP.
REQ-026 enc_done and timeout in the same cycle: enc_done SHALL win (err=0).
REQ-027 RESP: rsp_valid[grant_id]=1, with rsp_data and rsp_err valid, for exactly one cycle, then go to IDLE.
REQ-028 rsp_valid SHALL be zero outside RESP; enc_done outside WAIT SHALL be ignored.
REQ-029 req_ready SHALL be zero outside IDLE; requests arriving during a transaction SHALL wait.
REQ-030 Minimum accept-to-response latency SHALL be 3 cycles (enc_ready already high, enc_done on the first WAIT cycle).
REQ-031 Every internal counter and index SHALL wrap modulo its width with no overflow.

Reset
REQ-032 wb_rst_i SHALL, at the next rising edge, force IDLE, clear the counter and err, set last_grant=NREQ-1 (requester 0 first), grant_id=0, and drive all outputs 0.
REQ-033 Reset mid-transaction SHALL abandon it silently: no rsp_valid, and a later enc_done is ignored.

Structure
REQ-034 FSM state encoding, the NREQ/DW/OW/TMO defaults and clog2 SHALL live in the shared package encoder_pkg.
REQ-035 The round-robin picker SHALL be a separate sub-module, encoder_rr_pick (combinational; inputs req vector and last_grant; outputs one-hot grant and index).

Verification
REQ-036 Bench SHALL cover each of the following scenarios.
REQ-037 Single request: req_valid=4'b0001, data 16'h1234, enc_ready=1, enc_done one cycle after enc_valid with result 8'hA5 -> rsp_valid=4'b0001, rsp_data=8'hA5, rsp_err=0, 3 cycles after acceptance.
REQ-038 Fairness: req_valid=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-039 Backpressure: enc_ready low for 5 cycles -> enc_valid and enc_data stable all 5 cycles; req_ready stays 0.
REQ-040 Timeout with TMO=4: no enc_done -> rsp_err=1, rsp_data=0 after 4 WAIT cycles; a later enc_done is ignored.
REQ-041 Simultaneous events and reset: enc_done on the timeout cycle -> rsp_err=0; wb_rst_i asserted in WAIT -> outputs 0 next cycle, no rsp_valid, next grant goes to requester 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder arbiter: FSM encoding, parameter defaults
// and a clog2 helper usable in constant expressions.
package encoder_pkg;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 16;
   localparam int OW_DEF   = 8;
   localparam int TMO_DEF  = 255;

   // Timeout counter width; TMO is limited to 1..255 so 8 bits always suffice.
   localparam int CW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Ceiling log2, never below 1 so index vectors always have at least one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/encoder_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap
// and returns the first active requester as both a one-hot vector and an index.
module encoder_rr_pick
   import encoder_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            any
);

   // Candidate i is the requester i+1 positions past the last winner.
   logic [IW-1:0] cand_idx [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand_idx[gi] = IW'((32'(last_grant) + 32'(gi) + 32'd1) % 32'(NREQ));
      end
   endgenerate

   // First active candidate in search order wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[cand_idx[i]]) begin
            any                 = 1'b1;
            grant_idx           = cand_idx[i];
            grant[cand_idx[i]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_arb_ctrl.sv
// Arbitrates NREQ requesters onto a single encoder datapath, one transaction
// at a time: accept -> issue word -> wait for result (with timeout) -> respond.
module encoder_arb_ctrl
   import encoder_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int OW   = OW_DEF,
   parameter int TMO  = TMO_DEF
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DW-1:0]     req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic                   enc_valid,
   output logic [DW-1:0]          enc_data,
   input  logic                   enc_ready,
   input  logic                   enc_done,
   input  logic [OW-1:0]          enc_result,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [OW-1:0]          rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [clog2(NREQ)-1:0] grant_id
);

   localparam int IW = clog2(NREQ);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg;
   logic [DW-1:0]   data_reg;
   logic [OW-1:0]   result_reg;
   logic            err_reg;
   logic [IW-1:0]   grant_reg;
   logic [IW-1:0]   last_grant_reg;

   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            accept, issue_fire, done_hit, tmo_hit;

   encoder_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant_reg),
      .grant      (pick_grant),
      .grant_idx  (pick_idx),
      .any        (pick_any)
   );

   assign accept     = (state_reg == ST_IDLE)  && pick_any;
   assign issue_fire = (state_reg == ST_ISSUE) && enc_ready;
   assign done_hit   = (state_reg == ST_WAIT)  && enc_done;
   assign tmo_hit    = (state_reg == ST_WAIT)  && (cnt_reg == TMO_LAST);
   assign grant_id   = grant_reg;

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic; enc_done takes priority over a coincident timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept)                state_next = ST_ISSUE;
         ST_ISSUE: if (issue_fire)            state_next = ST_WAIT;
         ST_WAIT:  if (done_hit || tmo_hit)   state_next = ST_RESP;
         ST_RESP:                             state_next = ST_IDLE;
         default:                             state_next = ST_IDLE;
      endcase
   end

   // Datapath: captured word, grant bookkeeping, timeout counter, result/err.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt_reg        <= '0;
         data_reg       <= '0;
         result_reg     <= '0;
         err_reg        <= 1'b0;
         grant_reg      <= '0;
         last_grant_reg <= IW'(NREQ - 1);
      end else begin
         if (accept) begin
            data_reg       <= req_data[pick_idx*DW +: DW];
            grant_reg      <= pick_idx;
            last_grant_reg <= pick_idx;
         end
         if (issue_fire)
            cnt_reg <= '0;
         else if (state_reg == ST_WAIT)
            cnt_reg <= cnt_reg + 1'b1;
         if (done_hit) begin
            result_reg <= enc_result;
            err_reg    <= 1'b0;
         end else if (tmo_hit) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
         end
      end
   end

   // Outputs decoded from state; req_ready is masked while reset is asserted.
   always_comb begin
      req_ready = '0;
      enc_valid = 1'b0;
      enc_data  = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      busy      = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (!wb_rst_i) req_ready = pick_grant;
         end
         ST_ISSUE: begin
            enc_valid = 1'b1;
            enc_data  = data_reg;
         end
         ST_WAIT: begin
         end
         ST_RESP: begin
            rsp_valid[grant_reg] = 1'b1;
            rsp_data             = result_reg;
            rsp_err              = err_reg;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_encoder_arb_ctrl.sv
// Bench for encoder_arb_ctrl: table of transactions driven cycle by cycle,
// responses checked against a scoreboard queue, plus reset/timeout sequences.
module tb_encoder_arb_ctrl;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int OW   = 8;
   localparam int TMO  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0] req_ready;
   logic            enc_valid;
   logic [DW-1:0]   enc_data;
   logic            enc_ready;
   logic            enc_done;
   logic [OW-1:0]   enc_result;
   logic [NREQ-1:0] rsp_valid;
   logic [OW-1:0]   rsp_data;
   logic            rsp_err;
   logic            busy;
   logic [1:0]      grant_id;

   always #5 clk = ~clk;

   encoder_arb_ctrl #(.NREQ(NREQ), .DW(DW), .OW(OW), .TMO(TMO)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .enc_valid  (enc_valid),
      .enc_data   (enc_data),
      .enc_ready  (enc_ready),
      .enc_done   (enc_done),
      .enc_result (enc_result),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   typedef struct {
      logic [3:0] onehot;
      logic [7:0] data;
      logic       err;
      int         acc;
      int         lat;
   } exp_t;

   // rdly: ISSUE cycles with enc_ready low; ddly: WAIT cycle index of enc_done (-1 = never)
   typedef struct {
      logic [3:0] rv;
      int         rdly;
      int         ddly;
      logic [7:0] res;
      int         idx;
      logic       err;
      logic [7:0] data;
   } vec_t;

   exp_t  sb[$];
   vec_t  vecs[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc   = 0;
   logic [15:0] words [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Response monitor: every rsp_valid pops one expected record.
   always @(negedge clk) begin : mon
      exp_t e;
      cyc = cyc + 1;
      if (|rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
         end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
            chk("rsp_data",  32'(rsp_data),  32'(e.data));
            chk("rsp_err",   32'(rsp_err),   32'(e.err));
            chk("latency",   32'(cyc - e.acc), 32'(e.lat));
            $display("txn rsp=%b data=%h err=%b lat=%0d", rsp_valid, rsp_data, rsp_err, cyc - e.acc);
         end
      end
   end

   task automatic run_txn(input logic [3:0] rv, input int rdly, input int ddly,
                          input logic [7:0] res, input int idx, input logic err,
                          input logic [7:0] data);
      exp_t e;
      bit   seen;
      @(negedge clk);
      req_valid = rv;
      enc_ready = 1'b0;
      enc_done  = 1'b0;
      #1;
      chk("req_ready", 32'(req_ready), 32'(1 << idx));
      e.onehot = 4'(1 << idx);
      e.data   = data;
      e.err    = err;
      e.acc    = cyc;
      e.lat    = (ddly < 0) ? rdly + 2 + TMO : rdly + ddly + 3;
      sb.push_back(e);
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         enc_ready = 1'b0;
         #1;
         chk("bp_enc_valid", 32'(enc_valid), 32'(1));
         chk("bp_enc_data",  32'(enc_data),  32'(words[idx]));
         chk("bp_req_ready", 32'(req_ready), 32'(0));
      end
      @(negedge clk);
      enc_ready = 1'b1;
      #1;
      chk("enc_valid", 32'(enc_valid), 32'(1));
      chk("enc_data",  32'(enc_data),  32'(words[idx]));
      chk("grant_id",  32'(grant_id),  32'(idx));
      seen = 1'b0;
      for (int j = 0; j < 20 && !seen; j++) begin
         @(negedge clk);
         enc_ready  = 1'b0;
         enc_done   = (j == ddly);
         enc_result = (j == ddly) ? res : 8'hEE;
         #1;
         if (|rsp_valid === 1'b1) seen = 1'b1;
         else chk("wait_req_ready", 32'(req_ready), 32'(0));
      end
      if (!seen) chk("rsp_timeout", 32'(0), 32'(1));
      enc_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      words[0] = 16'h1234;
      words[1] = 16'h5678;
      words[2] = 16'h9ABC;
      words[3] = 16'hDEF0;
      req_data   = {words[3], words[2], words[1], words[0]};
      req_valid  = 4'b1111;
      enc_ready  = 1'b0;
      enc_done   = 1'b0;
      enc_result = '0;
      rst        = 1'b1;

      // Fairness: all four requesting, grant order 0,1,2,3,0,1,2,3.
      for (int i = 0; i < 8; i++)
         vecs.push_back('{4'b1111, 0, i % 3, 8'(16 + i), i % 4, 1'b0, 8'(16 + i)});
      vecs.push_back('{4'b0001, 0,  0, 8'hA5, 0, 1'b0, 8'hA5});  // single request, 3-cycle latency
      vecs.push_back('{4'b1010, 0,  0, 8'h21, 1, 1'b0, 8'h21});  // wrap search from 1
      vecs.push_back('{4'b1010, 0,  2, 8'h22, 3, 1'b0, 8'h22});  // skip idle requester 2
      vecs.push_back('{4'b0100, 5,  1, 8'h3C, 2, 1'b0, 8'h3C});  // backpressure 5 cycles
      vecs.push_back('{4'b1000, 0, -1, 8'h00, 3, 1'b1, 8'h00});  // timeout
      vecs.push_back('{4'b0001, 0,  3, 8'h77, 0, 1'b0, 8'h77});  // done on timeout cycle
      vecs.push_back('{4'b0011, 1,  0, 8'h88, 1, 1'b0, 8'h88});

      // Reset state, with requests pending to show req_ready is held off.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_enc_valid", 32'(enc_valid), 32'(0));
      chk("rst_enc_data",  32'(enc_data),  32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_data",  32'(rsp_data),  32'(0));
      chk("rst_rsp_err",   32'(rsp_err),   32'(0));
      chk("rst_busy",      32'(busy),      32'(0));
      chk("rst_grant_id",  32'(grant_id),  32'(0));
      rst       = 1'b0;
      req_valid = 4'b0000;

      foreach (vecs[k]) begin
         run_txn(vecs[k].rv, vecs[k].rdly, vecs[k].ddly, vecs[k].res,
                 vecs[k].idx, vecs[k].err, vecs[k].data);
         if (vecs[k].ddly < 0) begin
            // A late enc_done after the timeout response must be ignored.
            @(negedge clk);
            req_valid  = 4'b0000;
            enc_done   = 1'b1;
            enc_result = 8'h99;
            #1;
            chk("late_done_busy", 32'(busy), 32'(0));
            @(negedge clk);
            enc_done = 1'b0;
            #1;
            chk("late_done_idle", 32'(busy), 32'(0));
         end
      end

      // Reset in WAIT: transaction abandoned, outputs cleared, grant restarts at 0.
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      chk("rw_req_ready", 32'(req_ready), 32'(4'b0100));
      @(negedge clk);
      req_valid = 4'b0000;
      enc_ready = 1'b1;
      #1;
      chk("rw_enc_valid", 32'(enc_valid), 32'(1));
      @(negedge clk);
      enc_ready = 1'b0;
      #1;
      chk("rw_wait_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      enc_done   = 1'b1;
      enc_result = 8'h55;
      #1;
      chk("rw_busy",      32'(busy),      32'(0));
      chk("rw_enc_valid0", 32'(enc_valid), 32'(0));
      chk("rw_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rw_grant_id",  32'(grant_id),  32'(0));
      @(negedge clk);
      enc_done = 1'b0;
      #1;
      chk("rw_idle", 32'(busy), 32'(0));
      run_txn(4'b1111, 0, 0, 8'hC3, 0, 1'b0, 8'hC3);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
